// File: rtl/saturn_bus_sequencer.sv
// Saturn bus sequencer: queues DATA/CMD/READ entries from the control
// unit and replays them onto the nibble bus, one per drive phase.
module saturn_bus_sequencer #(
    parameter int DEPTH    = 32,
    parameter int NIBBLE_W = 4,
    parameter int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [3:0]          i_phases,
    input  logic                i_debug_cycle,
    input  logic                i_push,
    input  logic [1:0]          i_push_kind,
    input  logic [NIBBLE_W-1:0] i_push_nibble,
    input  logic                i_clear_error,
    input  logic [NIBBLE_W-1:0] i_bus_nibble_in,
    output logic                o_ready,
    output logic                o_empty,
    output logic [LVL_W-1:0]    o_level,
    output logic                o_bus_clk_en,
    output logic                o_bus_is_data,
    output logic [NIBBLE_W-1:0] o_bus_nibble_out,
    output logic                o_rd_valid,
    output logic [NIBBLE_W-1:0] o_rd_nibble,
    output logic                o_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        K_DATA = 2'b00,
        K_CMD  = 2'b01,
        K_READ = 2'b10,
        K_ILL  = 2'b11
    } kind_t;

    logic [NIBBLE_W+1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                read_pending;
    logic                push_ok;
    logic                pop;
    logic                capture;
    kind_t               pop_kind;
    logic [NIBBLE_W-1:0] pop_nibble;

    assign o_ready    = (o_level != FULL);
    assign o_empty    = (o_level == '0);
    assign push_ok    = i_push && o_ready;
    // Emptiness comes from the registered level, so a fresh push is never
    // popped in the cycle it arrives.
    assign pop        = (i_phases == 4'b0001) && !i_debug_cycle && !o_empty
                        && !o_error && !read_pending;
    assign capture    = (i_phases == 4'b0010) && !i_debug_cycle && read_pending;
    assign pop_kind   = kind_t'(mem[rd_ptr][NIBBLE_W+1:NIBBLE_W]);
    assign pop_nibble = mem[rd_ptr][NIBBLE_W-1:0];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {i_push_kind, i_push_nibble};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                o_level <= o_level + LVL_W'(1);
            end else if (!push_ok && pop) begin
                o_level <= o_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_bus_clk_en     <= 1'b0;
            o_bus_is_data    <= 1'b0;
            o_bus_nibble_out <= '0;
            o_error          <= 1'b0;
            read_pending     <= 1'b0;
        end else begin
            o_bus_clk_en <= 1'b0;
            if (i_clear_error) begin
                o_error <= 1'b0;
            end
            if (capture) begin
                read_pending <= 1'b0;
            end
            if (pop) begin
                unique case (pop_kind)
                    K_DATA: begin
                        o_bus_clk_en     <= 1'b1;
                        o_bus_is_data    <= 1'b1;
                        o_bus_nibble_out <= pop_nibble;
                    end
                    K_CMD: begin
                        o_bus_clk_en     <= 1'b1;
                        o_bus_is_data    <= 1'b0;
                        o_bus_nibble_out <= pop_nibble;
                    end
                    K_READ: begin
                        o_bus_clk_en     <= 1'b1;
                        o_bus_is_data    <= 1'b1;
                        o_bus_nibble_out <= '0;
                        read_pending     <= 1'b1;
                    end
                    K_ILL: begin
                        o_error <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rd_valid  <= 1'b0;
            o_rd_nibble <= '0;
        end else begin
            o_rd_valid <= capture;
            if (capture) begin
                o_rd_nibble <= i_bus_nibble_in;
            end
        end
    end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Directed bench for saturn_bus_sequencer, built with a 4-entry queue
// so the full/wrap cases are reachable in a few cycles.
module tb_saturn_bus_sequencer;

    localparam int DEPTH = 4;
    localparam int NW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b1;
    logic [3:0]    i_phases = '0;
    logic          i_debug_cycle = 1'b0;
    logic          i_push = 1'b0;
    logic [1:0]    i_push_kind = '0;
    logic [NW-1:0] i_push_nibble = '0;
    logic          i_clear_error = 1'b0;
    logic [NW-1:0] i_bus_nibble_in = '0;
    logic          o_ready;
    logic          o_empty;
    logic [LW-1:0] o_level;
    logic          o_bus_clk_en;
    logic          o_bus_is_data;
    logic [NW-1:0] o_bus_nibble_out;
    logic          o_rd_valid;
    logic [NW-1:0] o_rd_nibble;
    logic          o_error;

    int tests = 0;
    int fails = 0;

    saturn_bus_sequencer #(.DEPTH(DEPTH), .NIBBLE_W(NW)) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_phases         (i_phases),
        .i_debug_cycle    (i_debug_cycle),
        .i_push           (i_push),
        .i_push_kind      (i_push_kind),
        .i_push_nibble    (i_push_nibble),
        .i_clear_error    (i_clear_error),
        .i_bus_nibble_in  (i_bus_nibble_in),
        .o_ready          (o_ready),
        .o_empty          (o_empty),
        .o_level          (o_level),
        .o_bus_clk_en     (o_bus_clk_en),
        .o_bus_is_data    (o_bus_is_data),
        .o_bus_nibble_out (o_bus_nibble_out),
        .o_rd_valid       (o_rd_valid),
        .o_rd_nibble      (o_rd_nibble),
        .o_error          (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] ph, input logic psh,
                       input logic [1:0] kind, input logic [3:0] nib,
                       input logic dbg, input logic clr);
        i_phases      = ph;
        i_push        = psh;
        i_push_kind   = kind;
        i_push_nibble = nib;
        i_debug_cycle = dbg;
        i_clear_error = clr;
        @(posedge i_clk);
        #1;
        i_phases      = '0;
        i_push        = 1'b0;
        i_debug_cycle = 1'b0;
        i_clear_error = 1'b0;
    endtask

    task automatic psh(input logic [1:0] kind, input logic [3:0] nib);
        cyc(4'b0000, 1'b1, kind, nib, 1'b0, 1'b0);
    endtask

    task automatic run(input logic [3:0] ph);
        cyc(ph, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input string tag, input logic d, input logic [3:0] n);
        chk({tag, "_en"}, o_bus_clk_en, 1);
        chk({tag, "_isdata"}, o_bus_is_data, d);
        chk({tag, "_nib"}, o_bus_nibble_out, n);
    endtask

    initial begin
        #1 i_reset_n = 1'b0;
        #1;
        chk("rst_level", o_level, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_ready", o_ready, 1);
        chk("rst_en", o_bus_clk_en, 0);
        chk("rst_isdata", o_bus_is_data, 0);
        chk("rst_nib", o_bus_nibble_out, 0);
        chk("rst_rdv", o_rd_valid, 0);
        chk("rst_rdn", o_rd_nibble, 0);
        chk("rst_err", o_error, 0);
        #10 i_reset_n = 1'b1;

        // CMD then DATA across phase sequence 1,2,4,8
        psh(2'b01, 4'h5);
        chk("seq_lvl1", o_level, 1);
        psh(2'b00, 4'hA);
        chk("seq_lvl2", o_level, 2);
        run(4'b0001);
        strobe("seq_cmd", 1'b0, 4'h5);
        chk("seq_lvl_a", o_level, 1);
        run(4'b0010);
        chk("seq_en_off", o_bus_clk_en, 0);
        chk("seq_hold", o_bus_nibble_out, 5);
        run(4'b0100);
        run(4'b1000);
        chk("seq_en_off2", o_bus_clk_en, 0);
        run(4'b0001);
        strobe("seq_data", 1'b1, 4'hA);
        chk("seq_lvl_b", o_level, 0);
        chk("seq_empty", o_empty, 1);

        // fill past DEPTH, then drain across the wrap
        for (int i = 1; i <= 4; i++) psh(2'b00, 4'(i));
        chk("full_ready", o_ready, 0);
        chk("full_lvl", o_level, 4);
        psh(2'b00, 4'h5);
        chk("drop_lvl", o_level, 4);
        for (int i = 1; i <= 4; i++) begin
            run(4'b0001);
            strobe("drain", 1'b1, 4'(i));
        end
        chk("drain_empty", o_empty, 1);
        chk("drain_ready", o_ready, 1);
        run(4'b0001);
        chk("drain_nopop", o_bus_clk_en, 0);

        // push into empty queue during a drive phase is not popped then
        cyc(4'b0001, 1'b1, 2'b00, 4'h9, 1'b0, 1'b0);
        chk("pe_noen", o_bus_clk_en, 0);
        chk("pe_lvl", o_level, 1);
        run(4'b0001);
        strobe("pe", 1'b1, 4'h9);

        // simultaneous push and pop keeps level
        psh(2'b00, 4'h1);
        psh(2'b00, 4'h2);
        cyc(4'b0001, 1'b1, 2'b00, 4'h3, 1'b0, 1'b0);
        strobe("pp", 1'b1, 4'h1);
        chk("pp_lvl", o_level, 2);
        run(4'b0001);
        strobe("pp2", 1'b1, 4'h2);
        run(4'b0001);
        strobe("pp3", 1'b1, 4'h3);
        chk("pp_lvl0", o_level, 0);

        // READ blocks later pops until captured; debug delays capture
        psh(2'b10, 4'hE);
        psh(2'b00, 4'h6);
        run(4'b0001);
        strobe("rd", 1'b1, 4'h0);
        chk("rd_lvl", o_level, 1);
        run(4'b0001);
        chk("rd_block", o_bus_clk_en, 0);
        chk("rd_block_lvl", o_level, 1);
        i_bus_nibble_in = 4'h3;
        cyc(4'b0010, 1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
        chk("rd_dbg", o_rd_valid, 0);
        run(4'b0010);
        chk("rd_valid", o_rd_valid, 1);
        chk("rd_nib", o_rd_nibble, 3);
        i_bus_nibble_in = 4'hC;
        run(4'b0010);
        chk("rd_pulse", o_rd_valid, 0);
        chk("rd_keep", o_rd_nibble, 3);
        run(4'b0001);
        strobe("rd_next", 1'b1, 4'h6);

        // non-one-hot phase and debug cycle
        psh(2'b00, 4'h4);
        run(4'b0011);
        chk("nonhot_en", o_bus_clk_en, 0);
        chk("nonhot_lvl", o_level, 1);
        cyc(4'b0001, 1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
        chk("dbg_en", o_bus_clk_en, 0);
        chk("dbg_lvl", o_level, 1);
        run(4'b0001);
        strobe("dbg", 1'b1, 4'h4);

        // illegal entry sets sticky error, pushes still accepted
        psh(2'b11, 4'hF);
        run(4'b0001);
        chk("ill_err", o_error, 1);
        chk("ill_en", o_bus_clk_en, 0);
        chk("ill_hold", o_bus_nibble_out, 4);
        psh(2'b00, 4'h7);
        chk("ill_pushlvl", o_level, 1);
        run(4'b0001);
        chk("ill_halt", o_bus_clk_en, 0);
        chk("ill_halt_lvl", o_level, 1);
        cyc(4'b0000, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
        chk("clr_err", o_error, 0);
        run(4'b0001);
        strobe("clr", 1'b1, 4'h7);

        // set wins over same-cycle clear
        psh(2'b11, 4'h0);
        cyc(4'b0001, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
        chk("setwins", o_error, 1);
        cyc(4'b0000, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
        chk("setwins_clr", o_error, 0);

        // reset with entries queued and a read pending
        psh(2'b10, 4'h0);
        psh(2'b00, 4'h1);
        psh(2'b00, 4'h2);
        psh(2'b00, 4'h3);
        run(4'b0001);
        chk("mr_lvl3", o_level, 3);
        i_reset_n = 1'b0;
        #1;
        chk("mr_lvl", o_level, 0);
        chk("mr_err", o_error, 0);
        chk("mr_empty", o_empty, 1);
        chk("mr_en", o_bus_clk_en, 0);
        #1 i_reset_n = 1'b1;
        run(4'b0001);
        chk("mr_nopop", o_bus_clk_en, 0);
        i_bus_nibble_in = 4'h9;
        run(4'b0010);
        chk("mr_nocap", o_rd_valid, 0);
        run(4'b0001);
        chk("mr_nopop2", o_bus_clk_en, 0);
        psh(2'b00, 4'h8);
        run(4'b0001);
        strobe("mr_new", 1'b1, 4'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
